// File: rtl/hazard_scoreboard.sv
// Stall and forwarding controller for the F/D/E/M/W pipeline. Tracks the E/M/W
// write records and the mult/div busy counter, and resolves RAW hazards per operand.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ext_stall,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic [1:0]    d_need_rs,
    input  logic [1:0]    d_need_rt,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [1:0]    d_rdy,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_clr,
    output logic          md_busy,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic [1:0]    fwd_rt_m
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
        logic          md_start;
        logic          md_div;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [1:0]    rdy;
    } e_rec_t;

    typedef struct packed {
        logic [AW-1:0] rt;
        logic          use_rt;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [1:0]    rdy;
    } m_rec_t;

    typedef struct packed {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
    } w_rec_t;

    e_rec_t        e_q, d_rec;
    m_rec_t        m_q;
    w_rec_t        w_q;
    logic [CW-1:0] cnt;

    function automatic logic match(input logic we, input logic [AW-1:0] wa,
                                   input logic [AW-1:0] a);
        return we && (wa == a) && (a != '0);
    endfunction

    // Only E and M can still be short of their ready stage; a W match never stalls.
    function automatic logic raw(input logic use_op, input logic e_hit, input logic m_hit,
                                 input logic [1:0] need, input logic [1:0] e_rdy,
                                 input logic [1:0] m_rdy);
        logic [2:0] sum;
        logic [2:0] rdy;
        sum = 3'd0;
        rdy = 3'd0;
        if (use_op && e_hit) begin
            sum = 3'd1 + {1'b0, need};
            rdy = {1'b0, e_rdy};
        end else if (use_op && m_hit) begin
            sum = 3'd2 + {1'b0, need};
            rdy = {1'b0, m_rdy};
        end
        return sum < rdy;
    endfunction

    function automatic logic [1:0] fwd_pick(input logic use_op, input logic e_hit,
                                            input logic m_hit, input logic m_fwd,
                                            input logic w_hit);
        if (!use_op || e_hit) return 2'd0;
        if (m_hit)            return m_fwd ? 2'd1 : 2'd0;
        if (w_hit)            return 2'd2;
        return 2'd0;
    endfunction

    logic drs_e, drs_m, drs_w, drt_e, drt_m, drt_w;
    logic ers_m, ers_w, ert_m, ert_w, mrt_w;
    logic raw_rs, raw_rt;

    assign drs_e = match(e_q.wr_en, e_q.wr_addr, d_rs);
    assign drs_m = match(m_q.wr_en, m_q.wr_addr, d_rs);
    assign drs_w = match(w_q.wr_en, w_q.wr_addr, d_rs);
    assign drt_e = match(e_q.wr_en, e_q.wr_addr, d_rt);
    assign drt_m = match(m_q.wr_en, m_q.wr_addr, d_rt);
    assign drt_w = match(w_q.wr_en, w_q.wr_addr, d_rt);
    assign ers_m = match(m_q.wr_en, m_q.wr_addr, e_q.rs);
    assign ers_w = match(w_q.wr_en, w_q.wr_addr, e_q.rs);
    assign ert_m = match(m_q.wr_en, m_q.wr_addr, e_q.rt);
    assign ert_w = match(w_q.wr_en, w_q.wr_addr, e_q.rt);
    assign mrt_w = match(w_q.wr_en, w_q.wr_addr, m_q.rt);

    assign raw_rs = raw(d_use_rs, drs_e, drs_m, d_need_rs, e_q.rdy, m_q.rdy);
    assign raw_rt = raw(d_use_rt, drt_e, drt_m, d_need_rt, e_q.rdy, m_q.rdy);

    assign md_busy   = (cnt != '0) || (e_q.valid && e_q.md_start);
    assign stall     = d_valid && (raw_rs || raw_rt || (d_md_use && md_busy));
    assign pc_en     = ~(stall | ext_stall);
    assign if_id_en  = ~(stall | ext_stall);
    assign id_ex_clr = stall & ~ext_stall;

    assign fwd_rs_d = fwd_pick(d_use_rs, drs_e, drs_m, m_q.rdy == 2'd2, drs_w);
    assign fwd_rt_d = fwd_pick(d_use_rt, drt_e, drt_m, m_q.rdy == 2'd2, drt_w);
    assign fwd_rs_e = fwd_pick(e_q.use_rs, 1'b0, ers_m, m_q.rdy == 2'd2, ers_w);
    assign fwd_rt_e = fwd_pick(e_q.use_rt, 1'b0, ert_m, m_q.rdy == 2'd2, ert_w);
    assign fwd_rt_m = fwd_pick(m_q.use_rt, 1'b0, 1'b0, 1'b0, mrt_w);

    // Writes to r0 are dropped here so no later match can ever see them.
    always_comb begin
        d_rec          = '0;
        d_rec.valid    = 1'b1;
        d_rec.rs       = d_rs;
        d_rec.rt       = d_rt;
        d_rec.use_rs   = d_use_rs;
        d_rec.use_rt   = d_use_rt;
        d_rec.md_start = d_md_start;
        d_rec.md_div   = d_md_div;
        d_rec.wr_en    = d_wr_en && (d_wr_addr != '0);
        d_rec.wr_addr  = d_wr_addr;
        d_rec.rdy      = (d_rdy < 2'd2) ? 2'd2 : d_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
            cnt <= '0;
        end else begin
            if (!ext_stall) begin
                w_q.wr_en   <= m_q.wr_en;
                w_q.wr_addr <= m_q.wr_addr;
                m_q.rt      <= e_q.rt;
                m_q.use_rt  <= e_q.use_rt;
                m_q.wr_en   <= e_q.wr_en;
                m_q.wr_addr <= e_q.wr_addr;
                m_q.rdy     <= e_q.rdy;
                e_q         <= (stall || !d_valid) ? '0 : d_rec;
            end
            if (!ext_stall && e_q.valid && e_q.md_start)
                cnt <= e_q.md_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule
